// File: rtl/iic_slave_receiver.sv
// iic_slave_receiver: write-only I2C target that ACKs its address, word address and data bytes,
// and strobes out each received data byte together with its auto-incremented word address.
module iic_slave_receiver #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] o_word_addr,
  output logic [7:0] o_write_data,
  output logic       o_data_valid,
  output logic       o_busy,
  output logic [3:0] o_state
);
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DEV      = 4'd1,
    DEV_ACK  = 4'd2,
    WORD     = 4'd3,
    WORD_ACK = 4'd4,
    DATA     = 4'd5,
    DATA_ACK = 4'd6,
    IGNORE   = 4'd7
  } state_t;
  state_t      state_q, state_n;
  logic [2:0]  scl_r, sda_r, cnt_q, cnt_n;
  logic [7:0]  sr_q, sr_n, ptr_q, ptr_n, wd_q, wd_n, wa_q, wa_n, byte_in;
  logic        ack_q, ack_n, busy_q, busy_n, valid_q, valid_n;
  logic        scl_s, scl_p, sda_s, sda_p, scl_rise, scl_fall, start, stop, addr_hit;
  assign scl_s    = scl_r[1];
  assign scl_p    = scl_r[2];
  assign sda_s    = sda_r[1];
  assign sda_p    = sda_r[2];
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start    = ~sda_s & sda_p & scl_s & scl_p;
  assign stop     = sda_s & ~sda_p & scl_s & scl_p;
  assign byte_in  = {sr_q[6:0], sda_s};
  assign addr_hit = byte_in == {DEV_ADDR, 1'b0};
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    sr_n    = sr_q;
    ptr_n   = ptr_q;
    ack_n   = ack_q;
    busy_n  = busy_q;
    wd_n    = wd_q;
    wa_n    = wa_q;
    valid_n = 1'b0;
    if (stop) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      ack_n   = 1'b0;
      cnt_n   = 3'd0;
    end else if (start) begin
      state_n = DEV;
      ack_n   = 1'b0;
      cnt_n   = 3'd0;
    end else begin
      case (state_q)
        DEV, WORD, DATA: if (scl_rise) begin
          sr_n  = byte_in;
          cnt_n = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (state_q == DEV) begin
              state_n = addr_hit ? DEV_ACK : IGNORE;
              busy_n  = busy_q | addr_hit;
            end else if (state_q == WORD) begin
              ptr_n   = byte_in;
              state_n = WORD_ACK;
            end else begin
              wd_n    = byte_in;
              wa_n    = ptr_q;
              valid_n = 1'b1;
              state_n = DATA_ACK;
            end
          end
        end
        // first falling edge starts driving ACK, the next one ends the ACK bit
        DEV_ACK, WORD_ACK, DATA_ACK: if (scl_fall) begin
          ack_n = ~ack_q;
          if (ack_q) begin
            state_n = (state_q == DEV_ACK) ? WORD : DATA;
            ptr_n   = (state_q == DATA_ACK) ? ptr_q + 8'd1 : ptr_q;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_r   <= 3'b111;
      sda_r   <= 3'b111;
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      sr_q    <= 8'd0;
      ptr_q   <= 8'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      wd_q    <= 8'd0;
      wa_q    <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      scl_r   <= {scl_r[1:0], scl};
      sda_r   <= {sda_r[1:0], sda};
      state_q <= state_n;
      cnt_q   <= cnt_n;
      sr_q    <= sr_n;
      ptr_q   <= ptr_n;
      ack_q   <= ack_n;
      busy_q  <= busy_n;
      wd_q    <= wd_n;
      wa_q    <= wa_n;
      valid_q <= valid_n;
    end
  end
  assign sda          = ack_q ? 1'b0 : 1'bz;
  assign o_word_addr  = wa_q;
  assign o_write_data = wd_q;
  assign o_data_valid = valid_q;
  assign o_busy       = busy_q;
  assign o_state      = state_q;
endmodule

// File: tb/tb_iic_slave_receiver.sv
// tb_iic_slave_receiver: bit-banged I2C write master against a transaction-level model of the target.
module tb_iic_slave_receiver;
  logic       clk, rst_n, scl, m_lo;
  wire        sda;
  logic [7:0] o_word_addr, o_write_data;
  logic       o_data_valid, o_busy;
  logic [3:0] o_state;
  int         n_cmp, n_err;
  logic [15:0] got_q[$], exp_q[$];
  logic [7:0]  tx[$];
  logic [7:0]  mptr;

  assign sda = m_lo ? 1'b0 : 1'bz;
  pullup (sda);

  iic_slave_receiver dut (
    .i_clk(clk), .i_rst_n(rst_n), .scl(scl), .sda(sda),
    .o_word_addr(o_word_addr), .o_write_data(o_write_data),
    .o_data_valid(o_data_valid), .o_busy(o_busy), .o_state(o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (o_data_valid) got_q.push_back({o_word_addr, o_write_data});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic q_wait;
    repeat (4) @(negedge clk);
  endtask

  task automatic i2c_start;
    m_lo = 1'b1; q_wait; scl = 1'b0; q_wait;
  endtask

  task automatic i2c_rstart;
    m_lo = 1'b0; q_wait; scl = 1'b1; q_wait; m_lo = 1'b1; q_wait; scl = 1'b0; q_wait;
  endtask

  task automatic i2c_stop;
    m_lo = 1'b1; q_wait; scl = 1'b1; q_wait; m_lo = 1'b0; q_wait; q_wait;
  endtask

  task automatic send_bit(input logic b);
    m_lo = ~b; q_wait; scl = 1'b1; q_wait; q_wait; scl = 1'b0; q_wait;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic a);
    send_bits(v, 8);
    m_lo = 1'b0; q_wait; scl = 1'b1; q_wait; a = sda; q_wait; scl = 1'b0; q_wait;
  endtask

  task automatic compare_strobes;
    check("strobe_count", got_q.size(), exp_q.size());
    foreach (exp_q[i]) check("strobe", i < got_q.size() ? {16'd0, got_q[i]} : 32'hxxxx, {16'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic write_txn(input logic [7:0] dev, input logic [7:0] wa);
    logic a;
    bit   ok;
    ok = (dev == 8'hA0);
    i2c_start;
    send_byte(dev, a);
    check("dev_ack", a, !ok);
    check("busy_mid", o_busy, ok);
    check("state_mid", o_state, ok ? 4'd3 : 4'd7);
    send_byte(wa, a);
    check("word_ack", a, !ok);
    if (ok) mptr = wa;
    foreach (tx[i]) begin
      send_byte(tx[i], a);
      check("data_ack", a, !ok);
      if (ok) begin
        exp_q.push_back({mptr, tx[i]});
        mptr = mptr + 8'd1;
      end
    end
    i2c_stop;
    check("busy_end", o_busy, 0);
    check("state_end", o_state, 0);
    check("sda_end", sda, 1);
    compare_strobes;
  endtask

  initial begin
    logic a;
    n_cmp = 0; n_err = 0; mptr = 8'd0;
    rst_n = 1'b0; scl = 1'b1; m_lo = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sda", sda, 1);
    check("rst_state", o_state, 0);
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_data_valid, 0);
    check("rst_wa", o_word_addr, 0);
    check("rst_wd", o_write_data, 0);
    rst_n = 1'b1;
    q_wait;

    tx = '{8'hA5};
    write_txn(8'hA0, 8'h12);
    tx = '{8'h3C};
    write_txn(8'hA2, 8'h77);
    tx = '{8'h11, 8'h22, 8'h33};
    write_txn(8'hA0, 8'hFE);

    // repeated start in the middle of a data byte
    i2c_start;
    send_byte(8'hA0, a);
    send_byte(8'h10, a);
    send_bits(8'hC3, 4);
    i2c_rstart;
    send_byte(8'hA0, a);
    check("rs_dev_ack", a, 0);
    send_byte(8'h40, a);
    send_byte(8'h5A, a);
    check("rs_data_ack", a, 0);
    i2c_stop;
    exp_q.push_back(16'h405A);
    mptr = 8'h41;
    compare_strobes;

    // stop after a partial data byte
    i2c_start;
    send_byte(8'hA0, a);
    send_byte(8'h20, a);
    send_bits(8'h77, 5);
    i2c_stop;
    mptr = 8'h20;
    check("pstop_state", o_state, 0);
    check("pstop_sda", sda, 1);
    check("pstop_busy", o_busy, 0);
    compare_strobes;

    // asynchronous reset while the address ACK is being driven
    i2c_start;
    send_bits(8'hA0, 8);
    m_lo = 1'b0;
    check("ack_low", sda, 0);
    check("ack_state", o_state, 2);
    rst_n = 1'b0;
    #1;
    check("rst_async_sda", sda, 1);
    check("rst_async_state", o_state, 0);
    check("rst_async_busy", o_busy, 0);
    check("rst_async_wd", o_write_data, 0);
    check("rst_async_wa", o_word_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mptr = 8'd0;
    i2c_stop;
    tx = '{8'hC4, 8'h5B};
    write_txn(8'hA0, 8'h33);

    for (int k = 0; k < 20; k++) begin
      int sel, n;
      logic [7:0] dev;
      sel = $urandom_range(0, 5);
      dev = (sel == 0) ? 8'hA2 : (sel == 1) ? 8'hA1 : 8'hA0;
      n = $urandom_range(1, 4);
      tx.delete();
      for (int j = 0; j < n; j++) tx.push_back(8'($urandom));
      write_txn(dev, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/iic_slave_receiver.md
# iic_slave_receiver

I2C write-only target (slave) that terminates the bus transactions produced by the team's I2C write master: START, 7-bit device address + W, 8-bit word address, one or more data bytes, STOP. It oversamples SCL/SDA on the local system clock, ACKs matching bytes by pulling SDA low, and presents each received data byte with its word address as a one-cycle strobe. It sits on the peripheral side of the bus, in front of a register bank or configuration store.

## Interface
- DEV_ADDR, 7'h50, 7-bit address this target responds to.
- i_clk  in  1  system clock; frequency must be at least 8× the SCL frequency.
- i_rst_n  in  1  asynchronous, active-low reset.
- scl  in  1  I2C clock from master, asynchronous to i_clk.
- sda  inout  1  I2C data, open-drain. Drives 1'b0 when ACKing, otherwise 1'bz.
- o_word_addr  out  8  word address of the current data byte.
- o_write_data  out  8  received data byte.
- o_data_valid  out  1  one-cycle strobe: o_word_addr/o_write_data valid.
- o_busy  out  1  high from a START addressed to this target until STOP/abort.
- o_state  out  4  current FSM state, for debug.

## Operation
- Input conditioning: scl and sda each pass through a 2-FF synchronizer, then a third register (previous value). scl_rise = s & ~p; scl_fall = ~s & p.
- START = sda_s falling while scl_s high and scl_p high. STOP = sda_s rising while scl_s high and scl_p high. Both are valid from every state, including mid-byte.
- Bits are shifted in MSB-first on scl_rise. A 3-bit counter counts 0..7. The byte is complete on the 8th scl_rise.
- States (o_state encoding):
  - IDLE=0: wait for START.
  - DEV=1: shift the address byte.
  - DEV_ACK=2: drive the ACK for the address byte.
  - WORD=3: shift the word-address byte.
  - WORD_ACK=4: drive the ACK for the word-address byte.
  - DATA=5: shift a data byte.
  - DATA_ACK=6: drive the ACK for a data byte.
  - IGNORE=7: wait for STOP/START with SDA released.
- Transitions:
  - START from any state goes to DEV. Counter clears, sda is released, o_busy stays as-is.
  - DEV complete: if byte[7:1]==DEV_ADDR and byte[0]==0, go to DEV_ACK and set o_busy=1. Otherwise go to IGNORE (NACK, SDA stays released). This includes R/W=1, since reads are unsupported.
  - WORD complete: load the internal address pointer with the byte, then go to WORD_ACK.
  - DATA complete: go to DATA_ACK. o_write_data <= byte, o_word_addr <= pointer, and o_data_valid pulses in the same cycle as the completing scl_rise+pipeline.
  - In each *_ACK state, SDA is driven low from the first scl_fall after byte completion until the next scl_fall (one full SCL high phase). Then SDA is released and the FSM goes to the next state: DEV_ACK→WORD, WORD_ACK→DATA, DATA_ACK→DATA.
  - Pointer increments by 1 on each DATA_ACK exit, wrapping 8'hFF→8'h00.
  - STOP from any state goes to IDLE: o_busy=0, sda released, counter cleared. A partial byte is discarded with no strobe.
- The pointer and last o_word_addr/o_write_data hold their values across transactions until overwritten.

## Timing
- Reset values: sda=z (released), o_word_addr=0, o_write_data=0, o_data_valid=0, o_busy=0, o_state=IDLE. Reset mid-ACK releases SDA immediately (async).
- SCL/SDA edge to internal detection takes 3 i_clk cycles: 2 sync stages plus 1 edge register.
- ACK assert takes 3 i_clk cycles after the master's SCL falling edge. The master must not sample before SCL rise, which satisfies this at ≥8× oversampling.
- ACK release takes 3 i_clk cycles after the SCL falling edge that ends the ACK bit. SDA is never changed while scl_s is high.
- o_data_valid is high for exactly 1 i_clk per data byte, aligned to detection of the 8th rising edge.
- START/STOP detection takes priority over a simultaneous scl edge in the same cycle.
- Glitches shorter than 1 i_clk are not filtered. This is outside scope.

## Test plan
- Write 0xA0 (0x50+W), word 0x12, data 0xA5, STOP:
  - Three ACKs are seen low on SDA.
  - One o_data_valid with o_word_addr=0x12 and o_write_data=0xA5.
  - o_busy is 1→0 at STOP.
- Address 0xA2 (0x51+W): SDA stays high at all 9th clocks, there is no strobe, o_busy=0, and o_state=7 until STOP returns it to 0.
- Word 0xFE, data 0x11/0x22/0x33: strobes give (0xFE,0x11), (0xFF,0x22), (0x00,0x33), confirming wrap.
- Repeated START after 4 bits of the data byte, followed by 0xA0/0x40/0x5A/STOP: the partial byte yields no strobe, and a single strobe gives (0x40,0x5A).
- STOP after 5 data bits: no strobe, o_state=0, SDA released.
- i_rst_n asserted while DEV_ACK is driving SDA low: SDA goes to z in the same cycle, all outputs take their reset values, and the next full write is received correctly.
